// File: rtl/slice_piece_emitter_if.sv
// slice_piece_emitter_if
// Bundles the start request and the piece-descriptor valid/ready stream of
// slice_piece_emitter.
//   slave  : emitter side (takes start/slice/base/ready, drives descriptors and status)
//   master : requester/consumer side (the mirror image)
// Signals:
//   start_i, slice_num_i[4:0], base_x_i[X_W-1:0]      start request and its operands
//   busy_o, done_o, err_o                             status
//   piece_valid_o, piece_ready_i                      descriptor handshake
//   piece_idx_o[3:0], piece_x0_o, piece_x1_o, piece_last_o   descriptor payload
interface slice_piece_emitter_if #(
  parameter int unsigned X_W = 10
);
  logic           start_i;
  logic [4:0]     slice_num_i;
  logic [X_W-1:0] base_x_i;
  logic           busy_o;
  logic           piece_valid_o;
  logic           piece_ready_i;
  logic [3:0]     piece_idx_o;
  logic [X_W-1:0] piece_x0_o;
  logic [X_W-1:0] piece_x1_o;
  logic           piece_last_o;
  logic           done_o;
  logic           err_o;

  modport slave (
    input  start_i, slice_num_i, base_x_i, piece_ready_i,
    output busy_o, piece_valid_o, piece_idx_o, piece_x0_o, piece_x1_o, piece_last_o,
           done_o, err_o
  );

  modport master (
    output start_i, slice_num_i, base_x_i, piece_ready_i,
    input  busy_o, piece_valid_o, piece_idx_o, piece_x0_o, piece_x1_o, piece_last_o,
           done_o, err_o
  );
endinterface

// File: rtl/slice_piece_emitter.sv
// slice_piece_emitter
// On a start request, latches the slice count (0/2/4/8/16) and the object base x, then
// emits one descriptor per piece (index, left x, inclusive right x, last flag) over a
// valid/ready stream. All descriptor and status outputs are registered.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    slice_piece_emitter_if.slave (start request, descriptor stream, busy/done/err)
// Parameters:
//   X_W    x-coordinate width; all coordinate sums wrap modulo 2^X_W
//   OBJ_W  object width in pixels, power of two, >= 16
// Optional feature (macro SLICE_GAP_EN): when defined, every non-last piece ends one pixel
// early (x1 = x0 + PW - 2), leaving a 1-pixel cut gap.
module slice_piece_emitter #(
  parameter int unsigned X_W   = 10,
  parameter int unsigned OBJ_W = 256
) (
  input logic                clk,
  input logic                rst_n,
  slice_piece_emitter_if.slave bus
);

  localparam int unsigned LogObj = $clog2(OBJ_W);

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  state_e         r_state;
  logic [2:0]     r_s;         // log2 of piece count
  logic [3:0]     r_last_idx;  // piece count minus one
  logic [X_W-1:0] r_base;

  logic           r_busy;
  logic           r_valid;
  logic [3:0]     r_idx;
  logic [X_W-1:0] r_x0;
  logic [X_W-1:0] r_x1;
  logic           r_last;
  logic           r_done;
  logic           r_err;

  // Slice-count decode
  logic       w_legal;
  logic [2:0] w_dec_s;
  logic [3:0] w_dec_last;

  always_comb begin
    w_legal    = 1'b1;
    w_dec_s    = 3'd0;
    w_dec_last = 4'd0;
    case (bus.slice_num_i)
      5'd0:  begin w_dec_s = 3'd0; w_dec_last = 4'd0;  end
      5'd2:  begin w_dec_s = 3'd1; w_dec_last = 4'd1;  end
      5'd4:  begin w_dec_s = 3'd2; w_dec_last = 4'd3;  end
      5'd8:  begin w_dec_s = 3'd3; w_dec_last = 4'd7;  end
      5'd16: begin w_dec_s = 3'd4; w_dec_last = 4'd15; end
      default: w_legal = 1'b0;
    endcase
  end

  // Next descriptor: piece 0 from the live inputs when starting, else the following piece
  // of the latched run.
  logic [X_W-1:0] w_src_base;
  logic [3:0]     w_src_idx;
  logic [2:0]     w_src_s;
  logic [3:0]     w_src_last_idx;
  logic [X_W-1:0] w_off;
  logic [X_W-1:0] w_pw;
  logic [X_W-1:0] w_x0;
  logic [X_W-1:0] w_x1;
  logic           w_last;

  always_comb begin
    if (r_state == StIdle) begin
      w_src_base     = bus.base_x_i;
      w_src_idx      = 4'd0;
      w_src_s        = w_dec_s;
      w_src_last_idx = w_dec_last;
    end else begin
      w_src_base     = r_base;
      w_src_idx      = r_idx + 4'd1;
      w_src_s        = r_s;
      w_src_last_idx = r_last_idx;
    end
    // idx * PW as a shift; truncation to X_W gives the intended wrap-around
    w_off  = X_W'(w_src_idx) << (LogObj - 32'(w_src_s));
    w_pw   = X_W'(OBJ_W >> w_src_s);
    w_x0   = w_src_base + w_off;
    w_x1   = w_x0 + w_pw - X_W'(1);
    w_last = (w_src_idx == w_src_last_idx);
`ifdef SLICE_GAP_EN
    if (!w_last) w_x1 = w_x1 - X_W'(1);
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_s        <= 3'd0;
      r_last_idx <= 4'd0;
      r_base     <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_idx      <= 4'd0;
      r_x0       <= '0;
      r_x1       <= '0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.start_i) begin
            if (w_legal) begin
              r_s        <= w_dec_s;
              r_last_idx <= w_dec_last;
              r_base     <= bus.base_x_i;
              r_busy     <= 1'b1;
              r_valid    <= 1'b1;
              r_idx      <= w_src_idx;
              r_x0       <= w_x0;
              r_x1       <= w_x1;
              r_last     <= w_last;
              r_state    <= StEmit;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        StEmit: begin
          if (bus.piece_ready_i) begin
            if (r_last) begin
              // Descriptor outputs read zero while not valid
              r_valid <= 1'b0;
              r_idx   <= 4'd0;
              r_x0    <= '0;
              r_x1    <= '0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_idx  <= w_src_idx;
              r_x0   <= w_x0;
              r_x1   <= w_x1;
              r_last <= w_last;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy_o        = r_busy;
  assign bus.piece_valid_o = r_valid;
  assign bus.piece_idx_o   = r_idx;
  assign bus.piece_x0_o    = r_x0;
  assign bus.piece_x1_o    = r_x1;
  assign bus.piece_last_o  = r_last;
  assign bus.done_o        = r_done;
  assign bus.err_o         = r_err;

endmodule

// File: tb/tb_slice_piece_emitter.sv
// tb_slice_piece_emitter
// Directed bench for slice_piece_emitter (X_W=10, OBJ_W=256). Inputs are driven and
// outputs sampled on the falling clock edge. Builds with or without SLICE_GAP_EN.
module tb_slice_piece_emitter;

  localparam int unsigned X_W = 10;
`ifdef SLICE_GAP_EN
  localparam logic [31:0] GapAdj = 32'd1;
`else
  localparam logic [31:0] GapAdj = 32'd0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slice_piece_emitter_if #(.X_W(X_W)) ifc ();

  slice_piece_emitter #(
    .X_W  (X_W),
    .OBJ_W(256)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Contiguous right edge, pulled in by one pixel on non-last pieces in gap mode
  function automatic logic [31:0] gx1(input logic [31:0] x1, input logic last);
    return last ? x1 : x1 - GapAdj;
  endfunction

  task automatic check_desc(input string tag, input int idx, input int x0, input int x1,
                            input logic last);
    check_eq({tag, " valid"}, 32'(ifc.piece_valid_o), 32'd1);
    check_eq({tag, " idx"},   32'(ifc.piece_idx_o), 32'(idx));
    check_eq({tag, " x0"},    32'(ifc.piece_x0_o), 32'(x0));
    check_eq({tag, " x1"},    32'(ifc.piece_x1_o), gx1(32'(x1), last));
    check_eq({tag, " last"},  32'(ifc.piece_last_o), 32'(last));
    check_eq({tag, " busy"},  32'(ifc.busy_o), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, " valid"}, 32'(ifc.piece_valid_o), 32'd0);
    check_eq({tag, " idx"},   32'(ifc.piece_idx_o), 32'd0);
    check_eq({tag, " x0"},    32'(ifc.piece_x0_o), 32'd0);
    check_eq({tag, " x1"},    32'(ifc.piece_x1_o), 32'd0);
    check_eq({tag, " last"},  32'(ifc.piece_last_o), 32'd0);
  endtask

  task automatic start_run(input logic [4:0] slice, input logic [9:0] base);
    ifc.start_i     = 1'b1;
    ifc.slice_num_i = slice;
    ifc.base_x_i    = base;
    @(negedge clk);
    ifc.start_i = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    check_quiet({tag, " done-cycle"});
    check_eq({tag, " done"}, 32'(ifc.done_o), 32'd1);
    check_eq({tag, " busy in done"}, 32'(ifc.busy_o), 32'd1);
    @(negedge clk);
    check_eq({tag, " done drop"}, 32'(ifc.done_o), 32'd0);
    check_eq({tag, " busy drop"}, 32'(ifc.busy_o), 32'd0);
  endtask

  initial begin
    ifc.start_i       = 1'b0;
    ifc.slice_num_i   = 5'd0;
    ifc.base_x_i      = '0;
    ifc.piece_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_quiet("reset");
    check_eq("reset busy", 32'(ifc.busy_o), 32'd0);
    check_eq("reset done", 32'(ifc.done_o), 32'd0);
    check_eq("reset err",  32'(ifc.err_o), 32'd0);

    // Uncut object: single piece spanning the full width
    start_run(5'd0, 10'd100);
    check_desc("n1", 0, 100, 355, 1'b1);
    @(negedge clk);
    expect_done("n1");

    // Four pieces back to back
    start_run(5'd4, 10'd0);
    check_desc("n4 p0", 0, 0, 63, 1'b0);    @(negedge clk);
    check_desc("n4 p1", 1, 64, 127, 1'b0);  @(negedge clk);
    check_desc("n4 p2", 2, 128, 191, 1'b0); @(negedge clk);
    check_desc("n4 p3", 3, 192, 255, 1'b1); @(negedge clk);
    expect_done("n4");

    // Sixteen pieces with wrap-around past 1023
    start_run(5'd16, 10'd1000);
    for (int k = 0; k < 16; k++) begin
      if (k == 2)       check_desc("n16 p2", 2, 8, 23, 1'b0);
      else if (k == 15) check_desc("n16 p15", 15, 216, 231, 1'b1);
      else begin
        check_eq("n16 valid", 32'(ifc.piece_valid_o), 32'd1);
        check_eq("n16 idx", 32'(ifc.piece_idx_o), 32'(k));
      end
      @(negedge clk);
    end
    expect_done("n16");

    // Back-pressure: idx0 held 3 cycles, start and input changes meanwhile ignored
    ifc.piece_ready_i = 1'b0;
    start_run(5'd2, 10'd50);
    for (int i = 0; i < 3; i++) begin
      check_desc("hold p0", 0, 50, 177, 1'b0);
      if (i == 1) begin
        ifc.start_i     = 1'b1;
        ifc.slice_num_i = 5'd8;
        ifc.base_x_i    = 10'd0;
      end
      if (i == 2) begin
        check_eq("hold no err", 32'(ifc.err_o), 32'd0);
        ifc.start_i       = 1'b0;
        ifc.piece_ready_i = 1'b1;
      end
      @(negedge clk);
    end
    check_desc("hold p1", 1, 178, 305, 1'b1);
    @(negedge clk);
    expect_done("hold");

    // Illegal slice counts
    start_run(5'd3, 10'd0);
    check_eq("ill3 err", 32'(ifc.err_o), 32'd1);
    check_eq("ill3 busy", 32'(ifc.busy_o), 32'd0);
    check_eq("ill3 valid", 32'(ifc.piece_valid_o), 32'd0);
    @(negedge clk);
    check_eq("ill3 err drop", 32'(ifc.err_o), 32'd0);
    check_eq("ill3 stay idle", 32'(ifc.piece_valid_o), 32'd0);
    start_run(5'd17, 10'd5);
    check_eq("ill17 err", 32'(ifc.err_o), 32'd1);
    check_eq("ill17 busy", 32'(ifc.busy_o), 32'd0);
    @(negedge clk);

    // Reset during piece 1 of an eight-piece run
    start_run(5'd8, 10'd0);
    check_desc("rst p0", 0, 0, 31, 1'b0);
    @(negedge clk);
    check_desc("rst p1", 1, 32, 63, 1'b0);
    rst_n = 1'b0;
    #1;
    check_quiet("rst async");
    check_eq("rst async busy", 32'(ifc.busy_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst no done", 32'(ifc.done_o), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst release busy", 32'(ifc.busy_o), 32'd0);
    check_eq("rst release valid", 32'(ifc.piece_valid_o), 32'd0);

    // Two pieces from zero (gap visible on piece 0 when SLICE_GAP_EN)
    start_run(5'd2, 10'd0);
    check_desc("n2 p0", 0, 0, 127, 1'b0);   @(negedge clk);
    check_desc("n2 p1", 1, 128, 255, 1'b1); @(negedge clk);
    expect_done("n2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
